// File: rtl/demux_1x2_reg.sv
// Registered 1-to-2 demultiplexer with valid/ready handshake.
// Each output channel has a one-entry holding register and a drain counter.
module demux_1x2_reg #(
    parameter int unsigned DATA_WIDTH  = 16,
    parameter int unsigned COUNT_WIDTH = 8
) (
    input  logic                   clock_in,
    input  logic                   reset_in,
    input  logic [DATA_WIDTH-1:0]  data_in,
    input  logic                   sel_1x2_in,
    input  logic                   valid_in,
    output logic                   ready_out,
    output logic [DATA_WIDTH-1:0]  out_0,
    output logic                   valid_0_out,
    input  logic                   ready_0_in,
    output logic [DATA_WIDTH-1:0]  out_1,
    output logic                   valid_1_out,
    input  logic                   ready_1_in,
    output logic [COUNT_WIDTH-1:0] count_0_out,
    output logic [COUNT_WIDTH-1:0] count_1_out
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } chan_state_e;

    chan_state_e            state_q [2];
    chan_state_e            state_d [2];
    logic [DATA_WIDTH-1:0]  data_q  [2];
    logic [DATA_WIDTH-1:0]  data_d  [2];
    logic [COUNT_WIDTH-1:0] count_q [2];
    logic [COUNT_WIDTH-1:0] count_d [2];

    logic [1:0] sink_ready;
    logic [1:0] space;
    logic [1:0] drain;
    logic [1:0] load;
    logic       accept;

    assign sink_ready = {ready_1_in, ready_0_in};

    // Handshake decode: ready_out looks only at the selected channel, never at valid_in.
    always_comb begin
        drain = '0;
        space = '0;
        for (int unsigned k = 0; k < 2; k++) begin
            drain[k] = (state_q[k] == FULL) & sink_ready[k];
            space[k] = (state_q[k] == EMPTY) | sink_ready[k];
        end
        ready_out = sel_1x2_in ? space[1] : space[0];
        accept    = valid_in & ready_out & ~reset_in;
        load      = {accept & sel_1x2_in, accept & ~sel_1x2_in};
    end

    always_ff @(posedge clock_in) begin
        if (reset_in) begin
            for (int unsigned k = 0; k < 2; k++) begin
                state_q[k] <= EMPTY;
                data_q[k]  <= '0;
                count_q[k] <= '0;
            end
        end else begin
            for (int unsigned k = 0; k < 2; k++) begin
                state_q[k] <= state_d[k];
                data_q[k]  <= data_d[k];
                count_q[k] <= count_d[k];
            end
        end
    end

    // A load wins over a drain on the same channel: back-to-back refill keeps FULL.
    always_comb begin
        for (int unsigned k = 0; k < 2; k++) begin
            state_d[k] = state_q[k];
            data_d[k]  = data_q[k];
            count_d[k] = count_q[k] + {{(COUNT_WIDTH-1){1'b0}}, drain[k]};
            if (load[k]) begin
                state_d[k] = FULL;
                data_d[k]  = data_in;
            end else if (drain[k]) begin
                state_d[k] = EMPTY;
            end
        end
    end

    always_comb begin
        out_0       = data_q[0];
        out_1       = data_q[1];
        valid_0_out = (state_q[0] == FULL);
        valid_1_out = (state_q[1] == FULL);
        count_0_out = count_q[0];
        count_1_out = count_q[1];
    end

endmodule

// File: doc/demux_1x2_reg.md
Name: demux_1x2_reg

Overview:
- Registered 1-to-2 demultiplexer with valid/ready handshake on the BIP2 16-bit datapath.
- Takes one input word stream and routes each accepted word to output 0 or output 1 according to a per-word select.
- Each output has a one-entry holding register, so either destination can stall without corrupting data.
- Per-output transfer counters support bring-up and debug.

Parameters:
- DATA_WIDTH, 16, width of data words.
- COUNT_WIDTH, 8, width of each per-output transfer counter.

Ports:
- clock_in  input  1  single clock; all state updates on the rising edge.
- reset_in  input  1  synchronous, active-high reset.
- data_in  input  DATA_WIDTH  input word.
- sel_1x2_in  input  1  destination of the current input word: 0 = out_0, 1 = out_1.
- valid_in  input  1  data_in and sel_1x2_in are valid.
- ready_out  output  1  block can accept the current input word this cycle.
- out_0  output  DATA_WIDTH  holding register of channel 0.
- valid_0_out  output  1  out_0 holds an undelivered word.
- ready_0_in  input  1  channel 0 sink accepts this cycle.
- out_1  output  DATA_WIDTH  holding register of channel 1.
- valid_1_out  output  1  out_1 holds an undelivered word.
- ready_1_in  input  1  channel 1 sink accepts this cycle.
- count_0_out  output  COUNT_WIDTH  number of completed channel 0 transfers.
- count_1_out  output  COUNT_WIDTH  number of completed channel 1 transfers.

Behaviour:
- Reset:
  - Synchronous, active-high, on the rising edge of clock_in.
  - Clears out_0, out_1, valid_0_out, valid_1_out, count_0_out and count_1_out to 0.
  - Words held when reset is asserted are discarded. Reset overrides all other activity in the same cycle.
  - ready_out is combinational and may read 1 during reset; no word is accepted while reset_in = 1.
- Per-channel state (channel k, k = 0 or 1):
  - EMPTY (valid_k_out = 0) or FULL (valid_k_out = 1).
  - drain_k = valid_k_out & ready_k_in.
  - space_k = !valid_k_out | ready_k_in.
- ready_out is combinational:
  - ready_out = space_1 when sel_1x2_in = 1, otherwise space_0.
  - No dependence on valid_in.
- accept = valid_in & ready_out & !reset_in.
  - sel_1x2_in is sampled only on accept.
  - While valid_in is held without accept, changing sel_1x2_in is permitted and simply re-targets the word.
- Channel k, next state on each rising edge:
  - Accept targeting k: out_k <= data_in, valid_k_out <= 1. This applies from EMPTY, or from FULL with drain_k in the same cycle (back-to-back, full throughput, no bubble).
  - drain_k with no accept targeting k: valid_k_out <= 0; out_k keeps its last value.
  - Otherwise: hold. While FULL and ready_k_in = 0, out_k and valid_k_out must stay stable.
- Latency: a word accepted at edge N appears on out_k with valid_k_out = 1 after edge N (one cycle).
- The two channels are independent:
  - Channel 0 may drain while channel 1 loads in the same cycle, and the reverse.
  - A stalled channel never blocks words destined for the other channel.
- Ordering: words to the same channel are delivered in acceptance order. There is no ordering guarantee across channels.
- Counters:
  - count_k_out increments by 1 on every drain_k.
  - Wraps from 2^COUNT_WIDTH - 1 to 0.
  - Not affected by accepts.
- ready_k_in asserted while valid_k_out = 0 has no effect: no count, no state change.

Test Plan:
- Reset then idle: reset_in = 1 for 2 cycles, then release -> valid_0_out = valid_1_out = 0, out_0 = out_1 = 0x0000, counts = 0; ready_out = 1 for both sel values.
- Single routes: send 0x0049 with sel = 1 and ready_1_in = 1 -> next cycle out_1 = 0x0049, valid_1_out = 1; following cycle valid_1_out = 0, count_1_out = 1. Then send 0x0064 with sel = 0 -> out_0 = 0x0064, count_0_out = 1.
- Stall and backpressure:
  - Hold ready_0_in = 0.
  - Send 0xFF49 with sel = 0 -> out_0 = 0xFF49 held stable and valid for 5 cycles.
  - Second word with sel = 0 -> ready_out = 0, not accepted.
  - Word 0x1234 with sel = 1 -> accepted and delivered on out_1.
  - Raise ready_0_in -> 0xFF49 delivered exactly once.
- Full throughput: ready_0_in = 1, stream 0x0001..0x0008 with sel = 0 on consecutive cycles -> ready_out stays 1, out_0 shows 0x0001..0x0008 in order on consecutive cycles, count_0_out = 8.
- Counter wrap: COUNT_WIDTH = 8, 256 transfers on channel 1 -> count_1_out returns to 0; count_0_out unchanged.
- Reset mid-operation: both channels FULL and stalled (0xAAAA, 0x5555), assert reset_in for 1 cycle -> both valids 0, outputs 0x0000, counts 0; the held words are never delivered after release.
